// File: rtl/counter_bounded_step_nbit_pkg.sv
// Shared encodings for the bounded step counter: direction and wrap/saturate mode.
package counter_bounded_step_nbit_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    typedef struct packed {
        logic ovf;
        logic unf;
    } cnt_evt_t;
endpackage

// File: rtl/counter_bounded_step_nbit_next.sv
// Combinational next-count: one step up/down with bound check, reporting boundary events.
module counter_bounded_step_nbit_next
    import counter_bounded_step_nbit_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic [CNT_WIDTH-1:0]  cnt_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [CNT_WIDTH-1:0]  min_i,
    input  logic [CNT_WIDTH-1:0]  max_i,
    input  logic                  dir_i,
    input  logic                  mode_i,
    output logic [CNT_WIDTH-1:0]  next_o,
    output cnt_evt_t              evt_o
);
    // One extra bit so cnt+step and min+step never alias at the top of the range.
    logic [CNT_WIDTH:0] cnt_x, step_x, min_x, max_x, sum_x, lim_x;

    assign cnt_x  = {1'b0, cnt_i};
    assign min_x  = {1'b0, min_i};
    assign max_x  = {1'b0, max_i};
    assign step_x = {{(CNT_WIDTH+1-STEP_WIDTH){1'b0}}, step_i};
    assign sum_x  = cnt_x + step_x;
    assign lim_x  = min_x + step_x;

    always_comb begin
        next_o = cnt_i;
        evt_o  = '0;
        if (step_i != '0) begin
            if (dir_i == DIR_UP) begin
                if (sum_x > max_x) begin
                    evt_o.ovf = 1'b1;
                    next_o    = (mode_i == MODE_SAT) ? max_i : min_i;
                end else begin
                    next_o = sum_x[CNT_WIDTH-1:0];
                end
            end else begin
                if (cnt_x < lim_x) begin
                    evt_o.unf = 1'b1;
                    next_o    = (mode_i == MODE_SAT) ? min_i : max_i;
                end else begin
                    next_o = cnt_i - step_x[CNT_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/counter_bounded_step_nbit.sv
// Bounded up/down counter: load clamp, priority mux, boundary pulse and sticky flags.
module counter_bounded_step_nbit
    import counter_bounded_step_nbit_pkg::*;
#(
    parameter int                 CNT_WIDTH  = 8,
    parameter int                 STEP_WIDTH = 4,
    parameter logic [CNT_WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load_en,
    input  logic                  up_down,
    input  logic                  sat_mode,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0]  min_val,
    input  logic [CNT_WIDTH-1:0]  max_val,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  clr_flags,
    output logic [CNT_WIDTH-1:0]  counter_out,
    output logic                  at_min,
    output logic                  at_max,
    output logic                  bound_pulse,
    output logic                  ovf_sticky,
    output logic                  unf_sticky,
    output logic                  cfg_err
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, step_cnt, load_cnt;
    logic                 pulse_q, pulse_d, ovf_q, ovf_d, unf_q, unf_d;
    cnt_evt_t             step_evt, evt;

    assign cfg_err = (min_val > max_val);

    counter_bounded_step_nbit_next #(
        .CNT_WIDTH (CNT_WIDTH),
        .STEP_WIDTH(STEP_WIDTH)
    ) u_next (
        .cnt_i (cnt_q),
        .step_i(step),
        .min_i (min_val),
        .max_i (max_val),
        .dir_i (up_down),
        .mode_i(sat_mode),
        .next_o(step_cnt),
        .evt_o (step_evt)
    );

    // With inverted bounds there is no valid range, so the load is taken as-is.
    always_comb begin
        load_cnt = counter_in;
        if (!cfg_err) begin
            if (counter_in < min_val)      load_cnt = min_val;
            else if (counter_in > max_val) load_cnt = max_val;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        evt   = '0;
        if (load_en) begin
            cnt_d = load_cnt;
        end else if (en && !cfg_err) begin
            cnt_d = step_cnt;
            evt   = step_evt;
        end
        pulse_d = evt.ovf | evt.unf;
        ovf_d   = evt.ovf | (ovf_q & ~clr_flags);
        unf_d   = evt.unf | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= RST_VAL;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign counter_out = cnt_q;
    assign at_min      = (cnt_q == min_val);
    assign at_max      = (cnt_q == max_val);
    assign bound_pulse = pulse_q;
    assign ovf_sticky  = ovf_q;
    assign unf_sticky  = unf_q;
endmodule

// File: tb/tb_counter_bounded_step_nbit.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares after each edge.
module tb_counter_bounded_step_nbit;
    localparam int CW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 0, load_en = 0, up_down = 0, sat_mode = 0, clr_flags = 0;
    logic [SW-1:0] step = '0;
    logic [CW-1:0] min_val = '0, max_val = '0, counter_in = '0;
    logic [CW-1:0] counter_out;
    logic          at_min, at_max, bound_pulse, ovf_sticky, unf_sticky, cfg_err;

    counter_bounded_step_nbit #(.CNT_WIDTH(CW), .STEP_WIDTH(SW), .RST_VAL('0)) dut (
        .clk(clk), .reset(reset), .en(en), .load_en(load_en), .up_down(up_down),
        .sat_mode(sat_mode), .step(step), .min_val(min_val), .max_val(max_val),
        .counter_in(counter_in), .clr_flags(clr_flags), .counter_out(counter_out),
        .at_min(at_min), .at_max(at_max), .bound_pulse(bound_pulse),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt; bit pulse; bit ovf; bit unf; bit amin; bit amax; bit cerr; string tag;
    } exp_t;
    exp_t q[$];

    int  checks = 0, failures = 0;
    int  m_cnt = 0;
    bit  m_ovf = 0, m_unf = 0;
    bit  done = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference model: applies one clock edge worth of the counter rules with integers.
    task automatic model_edge(input string tag);
        exp_t e;
        int   mn, mx, st, nc;
        bit   eo, eu;
        mn = min_val; mx = max_val; st = step;
        nc = m_cnt; eo = 0; eu = 0;
        if (reset) begin
            nc = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (load_en) begin
                nc = counter_in;
                if (mn <= mx) nc = (nc < mn) ? mn : (nc > mx) ? mx : nc;
            end else if (en && mn <= mx && st != 0) begin
                if (up_down) begin
                    if (m_cnt + st > mx) begin eo = 1; nc = sat_mode ? mx : mn; end
                    else nc = m_cnt + st;
                end else begin
                    if (m_cnt < mn + st) begin eu = 1; nc = sat_mode ? mn : mx; end
                    else nc = m_cnt - st;
                end
            end
            m_ovf = eo | (m_ovf & !clr_flags);
            m_unf = eu | (m_unf & !clr_flags);
        end
        m_cnt   = nc;
        e.cnt   = nc;
        e.pulse = reset ? 0 : (eo | eu);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.amin  = (nc == mn);
        e.amax  = (nc == mx);
        e.cerr  = (mn > mx);
        e.tag   = tag;
        q.push_back(e);
    endtask

    // Drive one cycle's inputs just after a falling edge, predict, then wait a cycle.
    task automatic cyc(input string tag, input bit r, input bit ld, input bit e_, input bit ud,
                       input bit sm, input int st, input int mn, input int mx, input int ci,
                       input bit clr);
        reset = r; load_en = ld; en = e_; up_down = ud; sat_mode = sm;
        step = SW'(st); min_val = CW'(mn); max_val = CW'(mx); counter_in = CW'(ci);
        clr_flags = clr;
        model_edge(tag);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".cnt"},   int'(counter_out), e.cnt);
                chk({e.tag, ".pulse"}, int'(bound_pulse), int'(e.pulse));
                chk({e.tag, ".ovf"},   int'(ovf_sticky),  int'(e.ovf));
                chk({e.tag, ".unf"},   int'(unf_sticky),  int'(e.unf));
                chk({e.tag, ".amin"},  int'(at_min),      int'(e.amin));
                chk({e.tag, ".amax"},  int'(at_max),      int'(e.amax));
                chk({e.tag, ".cerr"},  int'(cfg_err),     int'(e.cerr));
            end
        end
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        // 1: count to 7, then assert reset asynchronously mid-cycle
        cyc("t1_load", 0, 1, 0, 1, 0, 1, 0, 15, 6, 0);
        cyc("t1_up",   0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        reset = 1; #1;
        chk("t1_async_cnt",  int'(counter_out), 0);
        chk("t1_async_flag", int'({bound_pulse, ovf_sticky, unf_sticky}), 0);
        cyc("t1_rst",  1, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        cyc("t1_rel",  0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        cyc("t1_rel2", 0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        // 2: wrap up 5,7,9,3,5
        cyc("t2_load", 0, 1, 0, 1, 0, 2, 3, 9, 5, 1);
        for (int i = 0; i < 4; i++) cyc($sformatf("t2_up%0d", i), 0, 0, 1, 1, 0, 2, 3, 9, 0, 0);
        // 3: saturate down 8,5,3,3
        cyc("t3_load", 0, 1, 0, 0, 1, 3, 3, 9, 8, 1);
        for (int i = 0; i < 3; i++) cyc($sformatf("t3_dn%0d", i), 0, 0, 1, 0, 1, 3, 3, 9, 0, 0);
        // 4: clamped load beats en; full-range wrap 15 -> 0
        cyc("t4_clamp", 0, 1, 1, 1, 0, 1, 3, 9, 12, 1);
        cyc("t4_ld15",  0, 1, 0, 1, 0, 1, 0, 15, 15, 0);
        cyc("t4_wrap",  0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        // 5: inverted bounds hold; load honoured unclamped
        cyc("t5_hold0", 0, 0, 1, 1, 0, 1, 10, 4, 0, 0);
        cyc("t5_hold1", 0, 0, 1, 0, 1, 3, 10, 4, 0, 0);
        cyc("t5_load",  0, 1, 1, 1, 0, 1, 10, 4, 6, 0);
        // 6: set beats clear, then clear alone
        cyc("t6_ld",    0, 1, 0, 1, 0, 1, 0, 15, 14, 1);
        cyc("t6_up",    0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
        cyc("t6_setclr",0, 0, 1, 1, 0, 1, 0, 15, 0, 1);
        cyc("t6_clr",   0, 0, 0, 1, 0, 1, 0, 15, 0, 1);
        cyc("t6_step0", 0, 0, 1, 1, 1, 0, 0, 15, 0, 0);
        // random
        for (int i = 0; i < 600; i++) begin
            int mn, mx;
            mn = $urandom_range(0, 15);
            mx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(mn, 15);
            cyc("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), mn, mx, $urandom_range(0, 15),
                ($urandom_range(0, 7) == 0));
        end
        en = 0; load_en = 0; reset = 0;
        repeat (2) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
